pixie_dp_front_end: RTL and testbench

CPU-side half of the dual-port Pixie (CDP1861) display. Generates frame/line timing in CPU machine cycles, raises the DMA-out request, interrupt and EFx flag, and writes each DMA'd byte into the 1 KB framebuffer. The display back end reads that framebuffer independently on its own port.
- Framebuffer layout: 128 rows × 8 bytes.
- Address = {row[6:0], byte[2:0]}.

---
 rtl/pixie_dp_if.sv | 30 +++
 rtl/pixie_dp_front_end.sv | 101 ++++++++++
 tb/tb_pixie_dp_front_end.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pixie_dp_if.sv
// CPU-side bus of the dual-port Pixie front end: machine-cycle strobes, DMA handshake,
// CPU flags and the framebuffer write port.
interface pixie_dp_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LINE_W = 9;

    logic              clk_enable;
    logic              disp_on;
    logic              disp_off;
    logic              dma_ack;
    logic [DATA_W-1:0] data_in;
    logic              dmao;
    logic              int_n;
    logic              efx;
    logic              fb_wen;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic [LINE_W-1:0] line;

    modport master (
        output clk_enable, disp_on, disp_off, dma_ack, data_in,
        input  dmao, int_n, efx, fb_wen, fb_addr, fb_data, line
    );

    modport slave (
        input  clk_enable, disp_on, disp_off, dma_ack, data_in,
        output dmao, int_n, efx, fb_wen, fb_addr, fb_data, line
    );
endinterface

// File: rtl/pixie_dp_front_end.sv
// CPU-side half of the dual-port CDP1861 display: line/frame timing in machine cycles,
// DMA-out request, interrupt, EF flag and framebuffer byte writes.
module pixie_dp_front_end #(
    parameter int unsigned CYCLES_PER_LINE = 14,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned ACTIVE_START    = 80,
    parameter int unsigned ACTIVE_LINES    = 128,
    parameter int unsigned BYTES_PER_LINE  = 8,
    parameter int unsigned INT_LEAD        = 2,
    parameter int unsigned EFX_LEAD        = 4
) (
    input  logic        clk,
    input  logic        reset,
    pixie_dp_if.slave   bus
);
    localparam int unsigned MC_W       = 4;
    localparam int unsigned LINE_W     = 9;
    localparam int unsigned ROW_W      = 7;
    localparam int unsigned BYTE_W     = 3;
    localparam int unsigned ACTIVE_END = ACTIVE_START + ACTIVE_LINES;

    logic [MC_W-1:0]   mc;
    logic [LINE_W-1:0] line_q;
    logic [BYTE_W:0]   byte_q;
    logic              enabled;
    logic              line_en;

    logic              mc_last;
    logic              line_last;
    logic              wrap;
    logic              active;
    logic              int_win;
    logic              efx_win;
    logic              dma_win;
    logic              en_next;
    logic              wr_ok;
    logic [ROW_W-1:0]  row;

    // Decode of the current position and the per-clk write decision
    always_comb begin
        mc_last   = (mc == MC_W'(CYCLES_PER_LINE - 1));
        line_last = (line_q == LINE_W'(LINES_PER_FRAME - 1));
        wrap      = bus.clk_enable && mc_last;
        active    = (line_q >= LINE_W'(ACTIVE_START)) && (line_q < LINE_W'(ACTIVE_END));
        row       = ROW_W'(line_q - LINE_W'(ACTIVE_START));
        int_win   = (line_q >= LINE_W'(ACTIVE_START - INT_LEAD)) &&
                    (line_q <  LINE_W'(ACTIVE_START));
        efx_win   = ((line_q >= LINE_W'(ACTIVE_START - EFX_LEAD)) &&
                     (line_q <  LINE_W'(ACTIVE_START))) ||
                    ((line_q >= LINE_W'(ACTIVE_END - EFX_LEAD)) &&
                     (line_q <  LINE_W'(ACTIVE_END)));
        dma_win   = (mc < MC_W'(BYTES_PER_LINE));
        // disp_off has priority over a coincident disp_on
        en_next   = bus.disp_off ? 1'b0 : (bus.disp_on ? 1'b1 : enabled);
        wr_ok     = bus.dma_ack && line_en && active && !byte_q[BYTE_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc          <= '0;
            line_q      <= '0;
            byte_q      <= '0;
            enabled     <= 1'b0;
            line_en     <= 1'b0;
            bus.dmao    <= 1'b0;
            bus.int_n   <= 1'b1;
            bus.efx     <= 1'b0;
            bus.fb_wen  <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_data <= '0;
        end else begin
            enabled <= en_next;

            if (bus.clk_enable) begin
                mc <= mc_last ? '0 : mc + MC_W'(1);
                if (mc_last) begin
                    line_q <= line_last ? '0 : line_q + LINE_W'(1);
                end
            end

            bus.fb_wen <= wr_ok;
            if (wr_ok) begin
                bus.fb_addr <= {row, byte_q[BYTE_W-1:0]};
                bus.fb_data <= bus.data_in;
                byte_q      <= byte_q + (BYTE_W+1)'(1);
            end

            // Line boundary: latch the display enable and restart the byte index
            if (wrap) begin
                byte_q  <= '0;
                line_en <= enabled;
            end

            bus.dmao  <= line_en && active && dma_win;
            bus.int_n <= !(en_next && int_win);
            bus.efx   <= efx_win;
        end
    end

    assign bus.line = line_q;
endmodule

// File: tb/tb_pixie_dp_front_end.sv
// Scoreboard bench for pixie_dp_front_end: directed machine-cycle stimulus against a
// behavioural timing model; a monitor checks every framebuffer write in order.
module tb_pixie_dp_front_end;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pixie_dp_if bus();

    pixie_dp_front_end dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb[$];
    int  n_chk  = 0;
    int  n_err  = 0;
    int  wr_cnt = 0;

    // Behavioural model of the CPU-visible timing
    int m_mc   = 0;
    int m_line = 0;
    int m_byte = 0;
    bit m_en   = 1'b0;
    bit m_len  = 1'b0;

    function automatic bit is_active(input int l);
        return (l >= 80) && (l < 208);
    endfunction

    function automatic int exp_dmao();
        return (m_len && is_active(m_line) && (m_mc < 8)) ? 1 : 0;
    endfunction

    function automatic int exp_int_n();
        return (m_en && (m_line == 78 || m_line == 79)) ? 0 : 1;
    endfunction

    function automatic int exp_efx();
        return ((m_line >= 76 && m_line <= 79) || (m_line >= 204 && m_line <= 207)) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (model line %0d mc %0d, t=%0t)",
                     name, act, exp, m_line, m_mc, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic madv();
        m_mc++;
        if (m_mc == 14) begin
            m_mc   = 0;
            m_line = (m_line == 261) ? 0 : m_line + 1;
        end
        if (m_mc == 0) begin
            m_len  = m_en;
            m_byte = 0;
        end
    endtask

    // Issue one ack this clk; queue the expected write if the model accepts it
    task automatic mack();
        int addr;
        bus.data_in = 8'hA5;
        if (is_active(m_line) && m_len && m_byte < 8) begin
            addr        = (m_line - 80) * 8 + m_byte;
            bus.data_in = 8'(addr);
            sb.push_back('{addr: addr, data: addr & 255});
            m_byte++;
        end
    endtask

    // One machine cycle of len clks; n_ack<0 means ack once if dmao is seen high
    task automatic mcycle(input int n_ack, input int len);
        bit ack;
        bus.clk_enable = 1'b1;
        tick();
        bus.clk_enable = 1'b0;
        madv();
        tick();
        chk("dmao",  int'(bus.dmao),  exp_dmao());
        chk("int_n", int'(bus.int_n), exp_int_n());
        chk("efx",   int'(bus.efx),   exp_efx());
        chk("line",  int'(bus.line),  m_line);
        for (int s = 0; s < len - 2; s++) begin
            ack = (n_ack < 0) ? (bus.dmao === 1'b1 && s == 0) : (s < n_ack);
            bus.dma_ack = ack;
            if (ack) mack();
            tick();
        end
        bus.dma_ack = 1'b0;
    endtask

    task automatic ff_to(input int l, input int m);
        bus.clk_enable = 1'b1;
        while (!(m_line == l && m_mc == m)) begin
            tick();
            madv();
        end
        bus.clk_enable = 1'b0;
    endtask

    task automatic strobe(input bit on, input bit off);
        bus.disp_on  = on;
        bus.disp_off = off;
        tick();
        bus.disp_on  = 1'b0;
        bus.disp_off = 1'b0;
        m_en = off ? 1'b0 : (on ? 1'b1 : m_en);
        chk("int_n_strobe", int'(bus.int_n), exp_int_n());
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dmao"},    int'(bus.dmao),    0);
        chk({tag, "_int_n"},   int'(bus.int_n),   1);
        chk({tag, "_efx"},     int'(bus.efx),     0);
        chk({tag, "_fb_wen"},  int'(bus.fb_wen),  0);
        chk({tag, "_fb_addr"}, int'(bus.fb_addr), 0);
        chk({tag, "_fb_data"}, int'(bus.fb_data), 0);
        chk({tag, "_line"},    int'(bus.line),    0);
    endtask

    // Write monitor: every fb_wen must match the head of the scoreboard
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset && bus.fb_wen === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                         bus.fb_addr, bus.fb_data);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", int'(bus.fb_addr), e.addr);
                chk("wr_data", int'(bus.fb_data), e.data);
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0;
        int acks [14];
        acks = '{3, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        bus.clk_enable = 1'b0;
        bus.disp_on    = 1'b0;
        bus.disp_off   = 1'b0;
        bus.dma_ack    = 1'b0;
        bus.data_in    = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_outputs("por");

        // Display never enabled: no DMA, no interrupt, efx still framed
        repeat (3668) mcycle(1, 3);
        chk("disabled_writes", wr_cnt, 0);

        // Full frame with the CPU acking every dmao cycle
        strobe(1'b1, 1'b0);
        w0 = wr_cnt;
        repeat (3668) mcycle(-1, 8);
        chk("frame_writes", wr_cnt - w0, 1024);
        chk("frame_sb_empty", sb.size(), 0);

        // Ten acks in row 5, then a normal row 6
        ff_to(84, 13);
        w0 = wr_cnt;
        for (int i = 0; i < 14; i++) mcycle(acks[i], 8);
        repeat (14) mcycle(-1, 8);
        chk("row5_row6_writes", wr_cnt - w0, 16);

        // Coincident strobes: disp_off wins
        ff_to(78, 0);
        tick();
        chk("int_lead_low", int'(bus.int_n), 0);
        strobe(1'b1, 1'b1);
        strobe(1'b1, 1'b0);

        // disp_off mid-line 100: line completes, line 101 gets no DMA
        ff_to(99, 13);
        w0 = wr_cnt;
        repeat (3) mcycle(-1, 8);
        strobe(1'b0, 1'b1);
        repeat (11) mcycle(-1, 8);
        repeat (14) mcycle(1, 8);
        chk("disp_off_line_writes", wr_cnt - w0, 8);

        // Asynchronous reset while dmao is high
        strobe(1'b1, 1'b0);
        repeat (3) mcycle(-1, 8);
        chk("pre_reset_dmao", int'(bus.dmao), 1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        m_mc = 0; m_line = 0; m_byte = 0; m_en = 1'b0; m_len = 1'b0;
        chk("reset_sb_empty", sb.size(), 0);
        tick();
        reset = 1'b0;
        chk("post_reset_line", int'(bus.line), 0);
        w0 = wr_cnt;
        repeat (80 * 14) mcycle(1, 3);
        chk("post_reset_writes", wr_cnt - w0, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
